// File: rtl/mult_share_arb.sv
// Shares one pipelined multiplier among NUM_REQ requesters with tag tracking and a credit-protected response FIFO.
// Define MULT_SHARE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mult_share_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_LEN   = 32,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
    output logic [DATA_LEN-1:0]          mul_a,
    output logic [DATA_LEN-1:0]          mul_b,
    input  logic [DATA_LEN-1:0]          mul_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [DATA_LEN-1:0]          rsp_data,
    output logic                         busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W:0]      occupied;
    logic                credit_ok;

    logic                found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     idx;
    logic [DATA_LEN-1:0] sel_a, sel_b;
    logic                issue;

    logic [DATA_LEN-1:0] mul_a_q, mul_b_q;
    logic [LATENCY-1:0]  tag_vld_q;
    logic [ID_W-1:0]     tag_id_q [LATENCY];

    logic [ID_W-1:0]     fifo_id_q   [FIFO_DEPTH];
    logic [DATA_LEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                push, pop;

    // Credit covers both the multiplier pipeline and the FIFO, so a push can never overflow.
    assign occupied  = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign credit_ok = (occupied < (CNT_W+1)'(FIFO_DEPTH));

`ifdef MULT_SHARE_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    assign rr_ptr_d = issue ? win_id : rr_ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'(k);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == win_id) begin
                sel_a = req_a[k*DATA_LEN +: DATA_LEN];
                sel_b = req_b[k*DATA_LEN +: DATA_LEN];
                if (found && credit_ok && reset_n) begin
                    req_ready[k] = 1'b1;
                end
            end
        end
    end

    assign issue = |(req_valid & req_ready);
    assign push  = tag_vld_q[LATENCY-1];
    assign pop   = rsp_valid & rsp_ready;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            tag_vld_q  <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
            fifo_cnt_q <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            mul_a_q     <= issue ? sel_a : '0;
            mul_b_q     <= issue ? sel_b : '0;
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= win_id;
            for (int unsigned s = 1; s < LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q]   <= tag_id_q[LATENCY-1];
            fifo_data_q[wr_ptr_q] <= mul_result;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = (fifo_cnt_q != '0);
    assign rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q]   : '0;
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign busy      = (inflight_q != '0) || (fifo_cnt_q != '0);

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb with a LATENCY=2 multiplier model.
// Runs the round-robin scenario when MULT_SHARE_ARB_RR_EN is defined, fixed priority otherwise.
module tb_mult_share_arb;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_LEN   = 32;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        reset_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*DATA_LEN-1:0] req_a;
    logic [NUM_REQ*DATA_LEN-1:0] req_b;
    logic [DATA_LEN-1:0]         mul_a;
    logic [DATA_LEN-1:0]         mul_b;
    logic [DATA_LEN-1:0]         mul_result;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [1:0]                  rsp_id;
    logic [DATA_LEN-1:0]         rsp_data;
    logic                        busy;

    int checks = 0;
    int errors = 0;

    mult_share_arb #(
        .NUM_REQ   (NUM_REQ),
        .DATA_LEN  (DATA_LEN),
        .LATENCY   (LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_result(mul_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Attached multiplier: operand register lives in the DUT, one product register here.
    logic [DATA_LEN-1:0] mul_pipe;
    always @(posedge clk) mul_pipe <= mul_a * mul_b;
    assign mul_result = mul_pipe;

    task automatic test_reset;
        reset_n   = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '1;
        req_b     = '1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b mul_a=%h mul_b=%h rsp_valid=%b rsp_id=%0d rsp_data=%h busy=%b, required all zero",
                     req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        reset_n   = 1'b1;
    endtask

    task automatic test_single_request;
        @(negedge clk);
        req_a[2*DATA_LEN +: DATA_LEN] = 32'd7;
        req_b[2*DATA_LEN +: DATA_LEN] = 32'd6;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b, required 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({mul_a, mul_b} !== {32'd7, 32'd6}) begin
            errors++;
            $display("FAIL single_operands: mul_a=%0d mul_b=%0d, required 7 6", mul_a, mul_b);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy=%b, required 1", busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_rsp: rsp_valid=%b in cycle 2, required 0", rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 32'd42}) begin
            errors++;
            $display("FAIL single_rsp: valid=%b id=%0d data=%0d, required 1 2 42", rsp_valid, rsp_id, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_after_pop: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int hs = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_a[1*DATA_LEN +: DATA_LEN] = 32'(hs + 1);
            req_b[1*DATA_LEN +: DATA_LEN] = 32'd3;
            req_valid = 4'b0010;
            #1;
            if (req_ready == 4'b0010) hs++;
        end
        checks++;
        if (hs !== 4) begin
            errors++;
            $display("FAIL bp_handshakes: accepted=%0d, required 4", hs);
        end
        checks++;
        if ({req_ready, rsp_valid, busy} !== {4'b0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL bp_stalled: req_ready=%b rsp_valid=%b busy=%b, required 0000 1 1", req_ready, rsp_valid, busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) rsp_ready = 1'b1;
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 32'((k + 1) * 3)}) begin
                errors++;
                $display("FAIL bp_drain_%0d: valid=%b id=%0d data=%0d, required 1 1 %0d", k, rsp_valid, rsp_id, rsp_data, (k + 1) * 3);
            end
            if (k == 0) begin
                checks++;
                if (req_ready !== 4'b0000) begin
                    errors++;
                    $display("FAIL bp_no_early_credit: req_ready=%b, required 0000", req_ready);
                end
            end
            if (k == 1) begin
                checks++;
                if (req_ready !== 4'b0010) begin
                    errors++;
                    $display("FAIL bp_resume: req_ready=%b, required 0010", req_ready);
                end
                req_valid = '0;
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bp_empty: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_truncation;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_a[0 +: DATA_LEN] = 32'hFFFF_FFFF;
        req_b[0 +: DATA_LEN] = 32'd2;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL trunc_grant0: req_ready=%b, required 0001", req_ready);
        end
        @(negedge clk);
        req_a[3*DATA_LEN +: DATA_LEN] = 32'h0001_0000;
        req_b[3*DATA_LEN +: DATA_LEN] = 32'h0001_0000;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL trunc_grant3: req_ready=%b, required 1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL trunc_rsp0: valid=%b id=%0d data=%h, required 1 0 fffffffe", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 32'h0}) begin
            errors++;
            $display("FAIL trunc_rsp3: valid=%b id=%0d data=%h, required 1 3 00000000", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL trunc_idle: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_a[1*DATA_LEN +: DATA_LEN] = 32'd5;
        req_b[1*DATA_LEN +: DATA_LEN] = 32'd5;
        req_valid = 4'b0010;
        @(negedge clk);
        req_a[2*DATA_LEN +: DATA_LEN] = 32'd9;
        req_b[2*DATA_LEN +: DATA_LEN] = 32'd9;
        req_valid = 4'b0100;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, mul_a} !== {1'b1, 32'd9}) begin
            errors++;
            $display("FAIL midrst_before: busy=%b mul_a=%0d, required 1 9", busy, mul_a);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
            errors++;
            $display("FAIL midrst_async: ready=%b mul_a=%h mul_b=%h rsp_valid=%b rsp_id=%0d rsp_data=%h busy=%b, required all zero",
                     req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy);
        end
        @(negedge clk);
        req_valid = '0;
        reset_n   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_after_%0d: rsp_valid=%b busy=%b, required 0 0", c, rsp_valid, busy);
            end
        end
    endtask

`ifdef MULT_SHARE_ARB_RR_EN
    task automatic test_round_robin;
        int rcv = 0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*DATA_LEN +: DATA_LEN] = 32'(i + 1);
            req_b[i*DATA_LEN +: DATA_LEN] = 32'd10;
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: req_ready=%b, required %b", c, req_ready, 4'(1 << (c % 4)));
                end
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if ({rsp_id, rsp_data} !== {2'(rcv % 4), 32'((rcv % 4 + 1) * 10)}) begin
                    errors++;
                    $display("FAIL rr_rsp_%0d: id=%0d data=%0d, required %0d %0d", rcv, rsp_id, rsp_data, rcv % 4, (rcv % 4 + 1) * 10);
                end
                rcv++;
            end
        end
        checks++;
        if ({rcv, busy} !== {32'd8, 1'b0}) begin
            errors++;
            $display("FAIL rr_total: responses=%0d busy=%b, required 8 0", rcv, busy);
        end
        rsp_ready = 1'b0;
    endtask
`else
    task automatic test_fixed_priority;
        int rcv = 0;
        req_a[0 +: DATA_LEN]          = 32'd2;
        req_b[0 +: DATA_LEN]          = 32'd3;
        req_a[3*DATA_LEN +: DATA_LEN] = 32'd4;
        req_b[3*DATA_LEN +: DATA_LEN] = 32'd5;
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'b1001 : ((c == 8) ? 4'b1000 : 4'b0000);
            #1;
            if (c < 8) begin
                checks++;
                if (req_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL fp_grant_%0d: req_ready=%b, required 0001", c, req_ready);
                end
            end else if (c == 8) begin
                checks++;
                if (req_ready !== 4'b1000) begin
                    errors++;
                    $display("FAIL fp_grant3: req_ready=%b, required 1000", req_ready);
                end
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if ({rsp_id, rsp_data} !== ((rcv < 8) ? {2'd0, 32'd6} : {2'd3, 32'd20})) begin
                    errors++;
                    $display("FAIL fp_rsp_%0d: id=%0d data=%0d, required %0d %0d", rcv, rsp_id, rsp_data,
                             (rcv < 8) ? 0 : 3, (rcv < 8) ? 6 : 20);
                end
                rcv++;
            end
        end
        checks++;
        if ({rcv, busy} !== {32'd9, 1'b0}) begin
            errors++;
            $display("FAIL fp_total: responses=%0d busy=%b, required 9 0", rcv, busy);
        end
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_request();
        test_backpressure();
        test_truncation();
        test_reset_mid_op();
`ifdef MULT_SHARE_ARB_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
